// File: rtl/icache_refill_engine.sv
// Instruction-cache refill engine: issues one L2 request per miss, gathers
// sequence-tagged beats into a block and emits a one-cycle fill pulse.
module icache_refill_engine #(
    parameter int unsigned LINE_SIZE = 128,
    parameter int unsigned BEATS     = 4,
    parameter int unsigned ADDR_W    = 26,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         miss_valid_i,
    input  logic [ADDR_W-1:0]            miss_addr_i,
    output logic                         miss_ready_o,
    input  logic                         kill_i,
    output logic [ADDR_W-1:0]            l2_addr_o,
    output logic                         l2_valid_o,
    input  logic                         l2_ready_i,
    input  logic [LINE_SIZE-1:0]         l2_line_i,
    input  logic                         l2_valid_i,
    input  logic [$clog2(BEATS)-1:0]     l2_seq_num_i,
    output logic                         fill_valid_o,
    output logic [ADDR_W-1:0]            fill_addr_o,
    output logic [BEATS*LINE_SIZE-1:0]   fill_data_o,
    output logic                         busy_o,
    output logic                         timeout_o
);

    localparam int unsigned BLK_W   = BEATS * LINE_SIZE;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        DONE
    } state_e;

    state_e               state_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [BEATS-1:0]     mask_q;
    logic [BEATS-1:0]     mask_d;
    logic [BLK_W-1:0]     buf_q;
    logic [BLK_W-1:0]     buf_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic [ADDR_W-1:0]    fill_addr_q;
    logic [BLK_W-1:0]     fill_data_q;
    logic                 timeout_q;
    logic                 beat_c;
    logic                 full_c;
    logic                 expire_c;

    assign miss_ready_o = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign l2_valid_o   = (state_q == REQ) && l2_ready_i && !kill_i;
    assign l2_addr_o    = (state_q != IDLE) ? addr_q : '0;
    assign fill_valid_o = (state_q == DONE);
    assign fill_addr_o  = fill_addr_q;
    assign fill_data_o  = fill_data_q;
    assign timeout_o    = timeout_q;

    // Beat bookkeeping; completion and expiry include the beat of this cycle.
    always_comb begin
        beat_c   = l2_valid_i && ((state_q == WAIT) || (state_q == DRAIN));
        mask_d   = mask_q;
        buf_d    = buf_q;
        timer_d  = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + 1'b1;
        if (beat_c) begin
            mask_d[l2_seq_num_i] = 1'b1;
            timer_d              = '0;
            if (state_q == WAIT) begin
                buf_d[int'(l2_seq_num_i) * LINE_SIZE +: LINE_SIZE] = l2_line_i;
            end
        end
        full_c   = &mask_d;
        expire_c = !l2_valid_i && (timer_q == TIMER_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mask_q      <= '0;
            buf_q       <= '0;
            timer_q     <= '0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (miss_valid_i) begin
                        addr_q  <= miss_addr_i;
                        mask_q  <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (kill_i) begin
                        state_q <= IDLE;
                    end else if (l2_valid_o) begin
                        timer_q <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    mask_q  <= mask_d;
                    buf_q   <= buf_d;
                    timer_q <= timer_d;
                    // A kill wins over a completing beat; drain only if beats remain.
                    if (kill_i) begin
                        state_q <= full_c ? IDLE : DRAIN;
                    end else if (full_c) begin
                        fill_addr_q <= addr_q;
                        fill_data_q <= buf_d;
                        state_q     <= DONE;
                    end else if (expire_c) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                DRAIN: begin
                    mask_q  <= mask_d;
                    timer_q <= timer_d;
                    if (full_c) begin
                        state_q <= IDLE;
                    end else if (expire_c) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_engine.sv
// Directed bench for icache_refill_engine: a vector table for the cycle-exact
// flows plus hand sequences for timeout and mid-refill reset.
module tb_icache_refill_engine;

    localparam int unsigned LINE_SIZE = 128;
    localparam int unsigned BEATS     = 4;
    localparam int unsigned ADDR_W    = 26;
    localparam int unsigned TIMEOUT   = 64;
    localparam int unsigned BLK_W     = BEATS * LINE_SIZE;

    // Expected flags packed as {miss_ready, l2_valid, fill_valid, busy, timeout}
    localparam logic [4:0] E_IDLE = 5'b10000;
    localparam logic [4:0] E_REQ  = 5'b01010;
    localparam logic [4:0] E_BUSY = 5'b00010;
    localparam logic [4:0] E_DONE = 5'b00110;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  miss_valid_i;
    logic [ADDR_W-1:0]     miss_addr_i;
    logic                  miss_ready_o;
    logic                  kill_i;
    logic [ADDR_W-1:0]     l2_addr_o;
    logic                  l2_valid_o;
    logic                  l2_ready_i;
    logic [LINE_SIZE-1:0]  l2_line_i;
    logic                  l2_valid_i;
    logic [1:0]            l2_seq_num_i;
    logic                  fill_valid_o;
    logic [ADDR_W-1:0]     fill_addr_o;
    logic [BLK_W-1:0]      fill_data_o;
    logic                  busy_o;
    logic                  timeout_o;

    icache_refill_engine #(
        .LINE_SIZE (LINE_SIZE),
        .BEATS     (BEATS),
        .ADDR_W    (ADDR_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .miss_valid_i (miss_valid_i),
        .miss_addr_i  (miss_addr_i),
        .miss_ready_o (miss_ready_o),
        .kill_i       (kill_i),
        .l2_addr_o    (l2_addr_o),
        .l2_valid_o   (l2_valid_o),
        .l2_ready_i   (l2_ready_i),
        .l2_line_i    (l2_line_i),
        .l2_valid_i   (l2_valid_i),
        .l2_seq_num_i (l2_seq_num_i),
        .fill_valid_o (fill_valid_o),
        .fill_addr_o  (fill_addr_o),
        .fill_data_o  (fill_data_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int                reps;
        logic              mv;
        logic [ADDR_W-1:0] maddr;
        logic              kill;
        logic              rdy;
        logic              bv;
        logic [1:0]        seq;
        logic [7:0]        pat;
        logic [4:0]        e;
        logic [ADDR_W-1:0] eaddr;
        logic              cd;
        logic [31:0]       epats;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t v(input int reps, input logic mv, input logic [ADDR_W-1:0] maddr,
                               input logic kill, input logic rdy, input logic bv,
                               input logic [1:0] seq, input logic [7:0] pat, input logic [4:0] e,
                               input logic [ADDR_W-1:0] eaddr, input logic cd,
                               input logic [31:0] epats);
        vec_t r;
        r.reps = reps; r.mv = mv; r.maddr = maddr; r.kill = kill; r.rdy = rdy;
        r.bv = bv; r.seq = seq; r.pat = pat; r.e = e; r.eaddr = eaddr;
        r.cd = cd; r.epats = epats;
        return r;
    endfunction

    // Block whose beat k is byte pats[8k+:8] replicated across the beat.
    function automatic logic [BLK_W-1:0] blk(input logic [31:0] pats);
        logic [BLK_W-1:0] b;
        for (int k = 0; k < int'(BEATS); k++) begin
            b[k*LINE_SIZE +: LINE_SIZE] = {16{pats[k*8 +: 8]}};
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        miss_valid_i = 1'b0; miss_addr_i = '0; kill_i = 1'b0; l2_ready_i = 1'b1;
        l2_valid_i = 1'b0; l2_seq_num_i = '0; l2_line_i = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_row(input int i, input vec_t r);
        chk($sformatf("row%0d miss_ready", i), BLK_W'(miss_ready_o), BLK_W'(r.e[4]));
        chk($sformatf("row%0d l2_valid", i),   BLK_W'(l2_valid_o),   BLK_W'(r.e[3]));
        chk($sformatf("row%0d fill_valid", i), BLK_W'(fill_valid_o), BLK_W'(r.e[2]));
        chk($sformatf("row%0d busy", i),       BLK_W'(busy_o),       BLK_W'(r.e[1]));
        chk($sformatf("row%0d timeout", i),    BLK_W'(timeout_o),    BLK_W'(r.e[0]));
        chk($sformatf("row%0d l2_addr", i),    BLK_W'(l2_addr_o),    BLK_W'(r.eaddr));
        if (r.cd) begin
            chk($sformatf("row%0d fill_data", i), fill_data_o, blk(r.epats));
            if (r.e[2]) chk($sformatf("row%0d fill_addr", i), BLK_W'(fill_addr_o), BLK_W'(r.eaddr));
        end
    endtask

    task automatic build_table();
        logic [ADDR_W-1:0] a, b, k, c, d, g, h;
        a = 26'h0001234; b = 26'h0000100; k = 26'h0000555; c = 26'h2ABCDEF;
        d = 26'h0000777; g = 26'h0000040; h = 26'h1000001;
        // Basic fill, beats arrive 20 cycles after the request
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        vecs.push_back(v(1, 1, a, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_REQ, a, 0, 0));
        vecs.push_back(v(19, 0, 0, 0, 1, 0, 0, 8'h00, E_BUSY, a, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 0, 8'hA0, E_BUSY, a, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 1, 8'hA1, E_BUSY, a, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 2, 8'hA2, E_BUSY, a, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 3, 8'hA3, E_BUSY, a, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_DONE, a, 1, 32'hA3A2A1A0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 2, 8'hEE, E_IDLE, 0, 1, 32'hA3A2A1A0));
        // Backpressure: five stalled REQ cycles, then one request pulse
        vecs.push_back(v(1, 1, b, 0, 0, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        vecs.push_back(v(5, 0, 0, 0, 0, 0, 0, 8'h00, E_BUSY, b, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_REQ, b, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 0, 8'hC0, E_BUSY, b, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 1, 8'hC1, E_BUSY, b, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 2, 8'hC2, E_BUSY, b, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 3, 8'hC3, E_BUSY, b, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_DONE, b, 1, 32'hC3C2C1C0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        // Kill in REQ suppresses the request
        vecs.push_back(v(1, 1, k, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 0, 0, 8'h00, E_BUSY, k, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        // Out-of-order with a duplicate seq 2; miss offered during DONE is refused
        vecs.push_back(v(1, 1, c, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_REQ, c, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 2, 8'h22, E_BUSY, c, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 0, 8'h20, E_BUSY, c, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 2, 8'hBB, E_BUSY, c, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 3, 8'h23, E_BUSY, c, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 1, 8'h21, E_BUSY, c, 0, 0));
        vecs.push_back(v(1, 1, 26'h3FFFFFF, 0, 1, 0, 0, 8'h00, E_DONE, c, 1, 32'h23BB2120));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        // Kill after beat 1, drain beats 2 and 3
        vecs.push_back(v(1, 1, d, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_REQ, d, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 0, 8'hD0, E_BUSY, d, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 1, 8'hD1, E_BUSY, d, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 0, 0, 8'h00, E_BUSY, d, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 1, 2, 8'hD2, E_BUSY, d, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 3, 8'hD3, E_BUSY, d, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 1, 32'h23BB2120));
        // Following miss completes; kill during DONE has no effect
        vecs.push_back(v(1, 1, g, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_REQ, g, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 0, 8'h40, E_BUSY, g, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 1, 8'h41, E_BUSY, g, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 2, 8'h42, E_BUSY, g, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 3, 8'h43, E_BUSY, g, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 0, 0, 8'h00, E_DONE, g, 1, 32'h43424140));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        // Kill coincident with the final beat: no fill, idle next cycle
        vecs.push_back(v(1, 1, h, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_REQ, h, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 0, 8'h50, E_BUSY, h, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 1, 8'h51, E_BUSY, h, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 1, 2, 8'h52, E_BUSY, h, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 1, 3, 8'h53, E_BUSY, h, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, E_IDLE, 0, 1, 32'h43424140));
    endtask

    initial begin
        int to_seen;
        rst_i = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        build_table();
        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                miss_valid_i = vecs[i].mv;  miss_addr_i  = vecs[i].maddr;
                kill_i       = vecs[i].kill; l2_ready_i  = vecs[i].rdy;
                l2_valid_i   = vecs[i].bv;  l2_seq_num_i = vecs[i].seq;
                l2_line_i    = {16{vecs[i].pat}};
                @(negedge clk_i);
                check_row(i, vecs[i]);
                next_cycle();
            end
        end

        // Timeout: request, then no beats; pulse lands after the 64th idle WAIT cycle
        idle_inputs();
        miss_valid_i = 1'b1; miss_addr_i = 26'h0000ABC;
        next_cycle();
        miss_valid_i = 1'b0; miss_addr_i = '0;
        @(negedge clk_i);
        chk("to request", BLK_W'(l2_valid_o), BLK_W'(1'b1));
        next_cycle();
        to_seen = 0;
        for (int c = 1; c <= TIMEOUT + 2; c++) begin
            @(negedge clk_i);
            chk($sformatf("to cyc%0d timeout", c), BLK_W'(timeout_o), BLK_W'(c == TIMEOUT + 1));
            chk($sformatf("to cyc%0d busy", c), BLK_W'(busy_o), BLK_W'(c <= TIMEOUT));
            chk($sformatf("to cyc%0d fill", c), BLK_W'(fill_valid_o), BLK_W'(1'b0));
            if (timeout_o) to_seen++;
            next_cycle();
        end
        chk("to pulse count", BLK_W'(to_seen), BLK_W'(1));

        // Reset after beat 2; a late beat 3 must be ignored
        miss_valid_i = 1'b1; miss_addr_i = 26'h0000321;
        next_cycle();
        miss_valid_i = 1'b0; miss_addr_i = '0;
        next_cycle();
        for (int s = 0; s < 3; s++) begin
            l2_valid_i = 1'b1; l2_seq_num_i = 2'(s); l2_line_i = {16{8'h60}};
            next_cycle();
        end
        idle_inputs();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst miss_ready", BLK_W'(miss_ready_o), BLK_W'(1'b1));
        chk("rst l2_valid",   BLK_W'(l2_valid_o),   BLK_W'(1'b0));
        chk("rst busy",       BLK_W'(busy_o),       BLK_W'(1'b0));
        chk("rst fill_valid", BLK_W'(fill_valid_o), BLK_W'(1'b0));
        chk("rst timeout",    BLK_W'(timeout_o),    BLK_W'(1'b0));
        chk("rst l2_addr",    BLK_W'(l2_addr_o),    BLK_W'(0));
        chk("rst fill_addr",  BLK_W'(fill_addr_o),  BLK_W'(0));
        chk("rst fill_data",  fill_data_o,          '0);
        l2_valid_i = 1'b1; l2_seq_num_i = 2'd3; l2_line_i = {16{8'h63}};
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        chk("late beat busy",       BLK_W'(busy_o),       BLK_W'(1'b0));
        chk("late beat fill_valid", BLK_W'(fill_valid_o), BLK_W'(1'b0));
        chk("late beat miss_ready", BLK_W'(miss_ready_o), BLK_W'(1'b1));
        next_cycle();
        @(negedge clk_i);
        chk("late beat fill_valid+1", BLK_W'(fill_valid_o), BLK_W'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
